ofdm_cp_remover: RTL and testbench

Receive-side counterpart of the transmit IFFT modulator. The block takes the time-domain OFDM sample stream: each symbol is NCP cyclic-prefix samples followed by NFFT body samples. It discards the prefix and forwards the NFFT body samples, tagged with a start-of-symbol marker, to the downstream FFT demodulator. It sits between the RX front end (sync/CFO correction) and the FFT stage. Both sides use the same Wishbone-style streaming handshake as the rest of the OFDM chain.

---
 rtl/ofdm_cp_remover.sv | 131 +++++++++++++
 tb/tb_ofdm_cp_remover.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix from each received OFDM symbol and forwards the
// NFFT body samples, tagged with start-of-symbol and symbol index, to the FFT.
module ofdm_cp_remover #(
    parameter int unsigned NFFT = 256,
    parameter int unsigned NCP  = 32,
    parameter int unsigned SCW  = 8
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [31:0]     DAT_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    output logic [31:0]     DAT_O,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    input  logic            ACK_I,
    output logic            SOS_O,
    output logic [SCW-1:0]  SYM_CNT_O,
    output logic            ERR_O
);

    localparam int unsigned SYM_LEN = NFFT + NCP;
    localparam int unsigned CW      = $clog2(SYM_LEN);

    logic [CW-1:0]  samp_cnt;
    logic [CW-1:0]  samp_cnt_nxt;
    logic [CW-1:0]  cur_cnt;
    logic [SCW-1:0] sym_cnt;
    logic [SCW-1:0] sym_cnt_nxt;
    logic [SCW-1:0] cur_sym;
    logic           icyc;

    logic           out_halt;
    logic           ena;
    logic           frame_start;
    logic           frame_end;
    logic           is_body;
    logic           is_last;

    logic [31:0]    dat_nxt;
    logic           stb_nxt;
    logic           sos_nxt;
    logic [SCW-1:0] sym_out_nxt;
    logic           cyc_nxt;
    logic           err_nxt;

    assign WE_O = STB_O;

    // Handshake, frame edges and next-state computation
    always_comb begin
        out_halt    = STB_O & ~ACK_I;
        ena         = CYC_I & STB_I & WE_I;
        ACK_O       = ena & ~out_halt;
        frame_start = CYC_I & ~icyc;
        frame_end   = ~CYC_I & icyc;

        // A transfer in the frame-start cycle is sample 0 of symbol 0
        cur_cnt     = frame_start ? '0 : samp_cnt;
        cur_sym     = frame_start ? '0 : sym_cnt;
        is_body     = ACK_O & (cur_cnt >= CW'(NCP));
        is_last     = (cur_cnt == CW'(SYM_LEN - 1));

        samp_cnt_nxt = cur_cnt;
        sym_cnt_nxt  = cur_sym;
        err_nxt      = frame_start ? 1'b0 : ERR_O;
        cyc_nxt      = CYC_O;
        dat_nxt      = DAT_O;
        stb_nxt      = STB_O;
        sos_nxt      = SOS_O;
        sym_out_nxt  = SYM_CNT_O;

        if (ACK_O) begin
            if (is_last) begin
                samp_cnt_nxt = '0;
                sym_cnt_nxt  = cur_sym + SCW'(1);
            end else begin
                samp_cnt_nxt = cur_cnt + CW'(1);
            end
        end

        // Frame closed mid-symbol: flag it, already-forwarded body stays sent
        if (frame_end && (samp_cnt != '0)) begin
            err_nxt      = 1'b1;
            samp_cnt_nxt = '0;
        end

        if (frame_start) begin
            cyc_nxt = 1'b1;
        end else if (!CYC_I && !STB_O) begin
            cyc_nxt = 1'b0;
        end

        if (!out_halt) begin
            stb_nxt     = is_body;
            sos_nxt     = is_body & (cur_cnt == CW'(NCP));
            sym_out_nxt = cur_sym;
            if (is_body) begin
                dat_nxt = DAT_I;
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            samp_cnt  <= '0;
            sym_cnt   <= '0;
            icyc      <= 1'b0;
            DAT_O     <= '0;
            STB_O     <= 1'b0;
            CYC_O     <= 1'b0;
            SOS_O     <= 1'b0;
            SYM_CNT_O <= '0;
            ERR_O     <= 1'b0;
        end else begin
            samp_cnt  <= samp_cnt_nxt;
            sym_cnt   <= sym_cnt_nxt;
            icyc      <= CYC_I;
            DAT_O     <= dat_nxt;
            STB_O     <= stb_nxt;
            CYC_O     <= cyc_nxt;
            SOS_O     <= sos_nxt;
            SYM_CNT_O <= sym_out_nxt;
            ERR_O     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ofdm_cp_remover.sv
// Scoreboard bench for ofdm_cp_remover with NFFT=8, NCP=2: expected body
// samples are queued as inputs are accepted and popped as outputs are taken.
module tb_ofdm_cp_remover;

    localparam int unsigned NFFT = 8;
    localparam int unsigned NCP  = 2;
    localparam int unsigned SCW  = 8;
    localparam int unsigned SYM_LEN = NFFT + NCP;

    logic            CLK_I = 1'b0;
    logic            RST_I;
    logic [31:0]     DAT_I;
    logic            CYC_I;
    logic            STB_I;
    logic            WE_I;
    logic            ACK_O;
    logic [31:0]     DAT_O;
    logic            CYC_O;
    logic            STB_O;
    logic            WE_O;
    logic            ACK_I;
    logic            SOS_O;
    logic [SCW-1:0]  SYM_CNT_O;
    logic            ERR_O;

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;
    int m_cnt;
    int m_sym;
    logic [SCW-1:0] last_sos_sym;
    logic [40:0] sb[$];

    ofdm_cp_remover #(.NFFT(NFFT), .NCP(NCP), .SCW(SCW)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I),
        .STB_I(STB_I), .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
        .SOS_O(SOS_O), .SYM_CNT_O(SYM_CNT_O), .ERR_O(ERR_O)
    );

    initial forever #5 CLK_I = ~CLK_I;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 random
    initial begin
        logic t;
        t = 1'b1;
        ACK_I = 1'b1;
        forever begin
            @(posedge CLK_I);
            #1;
            t = ~t;
            case (ack_mode)
                1:       ACK_I = t;
                2:       ACK_I = 1'($urandom_range(0, 1));
                default: ACK_I = 1'b1;
            endcase
        end
    end

    // Output monitor: compare every taken output against the scoreboard
    initial begin
        logic [40:0] exp;
        forever begin
            @(negedge CLK_I);
            if (RST_I && STB_O && !ACK_I)
                check_eq("ack_o_halt", 64'(ACK_O), 64'(0));
            if (RST_I && STB_O && ACK_I) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '1;
                check_eq("out_sample", 64'({SOS_O, SYM_CNT_O, DAT_O}), 64'(exp));
                check_eq("we_o", 64'(WE_O), 64'(1));
                if (SOS_O) last_sos_sym = SYM_CNT_O;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        CYC_I = 1'b1;
        m_cnt = 0;
        m_sym = 0;
    endtask

    // Present one sample and wait (bounded) until it is acknowledged
    task automatic send(input logic [31:0] d, input bit gaps);
        int  n;
        logic acc;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                STB_I = 1'b0;
                @(posedge CLK_I);
                #1;
            end
        end
        STB_I = 1'b1;
        WE_I  = 1'b1;
        DAT_I = d;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge CLK_I);
            acc = ACK_O;
            @(posedge CLK_I);
            #1;
            n++;
        end
        if (!acc) begin
            check_eq("send_timeout", 64'(acc), 64'(1));
        end else begin
            if (m_cnt >= int'(NCP))
                sb.push_back({(m_cnt == int'(NCP)), SCW'(m_sym), d});
            if (m_cnt == int'(SYM_LEN) - 1) begin
                m_cnt = 0;
                m_sym++;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic end_frame(input logic exp_err);
        int n;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        @(negedge CLK_I);
        @(negedge CLK_I);
        check_eq("err_o_end", 64'(ERR_O), 64'(exp_err));
        n = 0;
        while (CYC_O && n < 20) begin
            @(negedge CLK_I);
            n++;
        end
        check_eq("cyc_o_fall", 64'(CYC_O), 64'(0));
        check_eq("sb_drained", 64'(sb.size()), 64'(0));
        @(posedge CLK_I);
        #1;
    endtask

    initial begin
        RST_I = 1'b0;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        DAT_I = '0;
        last_sos_sym = '1;
        repeat (3) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        @(negedge CLK_I);
        check_eq("rst_dat_o", 64'(DAT_O), 64'(0));
        check_eq("rst_stb_o", 64'(STB_O), 64'(0));
        check_eq("rst_cyc_o", 64'(CYC_O), 64'(0));
        check_eq("rst_sos_o", 64'(SOS_O), 64'(0));
        check_eq("rst_sym_cnt_o", 64'(SYM_CNT_O), 64'(0));
        check_eq("rst_err_o", 64'(ERR_O), 64'(0));
        @(posedge CLK_I);
        #1;

        // Continuous stream, three symbols
        ack_mode = 0;
        start_frame();
        for (int i = 0; i < 30; i++) send(32'(i), 1'b0);
        end_frame(1'b0);

        // Same stream under toggling backpressure
        ack_mode = 1;
        start_frame();
        for (int i = 0; i < 30; i++) send(32'(i), 1'b0);
        end_frame(1'b0);

        // Partial frame: 14 samples then CYC_I drops
        ack_mode = 0;
        start_frame();
        for (int i = 0; i < 14; i++) send(32'(i), 1'b0);
        end_frame(1'b1);

        // New frame clears the sticky error; its first samples are prefix
        start_frame();
        @(negedge CLK_I);
        check_eq("err_held", 64'(ERR_O), 64'(1));
        @(posedge CLK_I);
        #1;
        @(negedge CLK_I);
        check_eq("err_cleared", 64'(ERR_O), 64'(0));
        check_eq("cyc_o_rise", 64'(CYC_O), 64'(1));
        @(posedge CLK_I);
        #1;
        for (int i = 0; i < 10; i++) send(32'(100 + i), 1'b0);
        end_frame(1'b0);

        // Idle gaps on the input with random downstream readiness
        ack_mode = 2;
        start_frame();
        for (int i = 0; i < 30; i++) send(32'(i), 1'b1);
        end_frame(1'b0);

        // Reset after sample 5 of symbol 1, then a fresh frame
        ack_mode = 0;
        start_frame();
        for (int i = 0; i < 16; i++) send(32'(i), 1'b0);
        RST_I = 1'b0;
        CYC_I = 1'b0;
        STB_I = 1'b0;
        #1;
        check_eq("arst_dat_o", 64'(DAT_O), 64'(0));
        check_eq("arst_stb_o", 64'(STB_O), 64'(0));
        check_eq("arst_cyc_o", 64'(CYC_O), 64'(0));
        check_eq("arst_sos_o", 64'(SOS_O), 64'(0));
        check_eq("arst_sym_cnt_o", 64'(SYM_CNT_O), 64'(0));
        check_eq("arst_err_o", 64'(ERR_O), 64'(0));
        sb.delete();
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        start_frame();
        for (int i = 0; i < 10; i++) send(32'(200 + i), 1'b0);
        end_frame(1'b0);

        // Symbol counter wrap over 257 symbols
        start_frame();
        for (int s = 0; s < 257; s++)
            for (int k = 0; k < int'(SYM_LEN); k++)
                send(32'(s * 16 + k), 1'b0);
        end_frame(1'b0);
        check_eq("sym_cnt_wrap", 64'(last_sos_sym), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
